muldiv_iter: RTL

- Parametrised, iterative multiply/divide unit for the EX stage of the MIPS pipeline.
- Replaces the separate fixed-32-bit divider and multiplier instances with one shared engine.
- Supports MULT, MULTU, DIV and DIVU at configurable width.
- Produces a {hi,lo} result for the HILO register, a pipeline stall request, flush cancellation and a divide-by-zero flag.

---
 rtl/muldiv_iter.sv | 118 +++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// Shared iterative multiply/divide engine for the EX stage: shift-add MUL and
// restoring DIV on magnitudes, one bit per cycle, sign fix-up in a final cycle.
module muldiv_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic                 r_sa, r_sb;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done, r_dbz;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_madd, w_rsh, w_diff;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_fix;
  logic [WIDTH-1:0]     w_hi, w_lo;

  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed & a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_signed & b[WIDTH-1]) ? -b : b;

  // r_acc holds {partial product, remaining multiplier} for MUL,
  // {partial remainder, dividend/quotient bits} for DIV; r_opnd is mcand/divisor.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};
  assign w_rsh     = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rsh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo = r_acc[WIDTH-1:0];

  always_comb begin
    w_fix = r_acc;
    case (r_op)
      2'b00:   w_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;
      2'b10:   w_fix = {(r_sa ? -w_hi : w_hi), ((r_sa ^ r_sb) ? -w_lo : w_lo)};
      default: w_fix = r_acc;
    endcase
  end

  assign stall       = (r_state == S_IDLE & start & ~flush) | (r_state == S_RUN) | (r_state == S_FIX);
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_op   <= op;
            r_sa   <= w_signed & a[WIDTH-1];
            r_sb   <= w_signed & b[WIDTH-1];
            r_cnt  <= CNT_W'(WIDTH);
            r_opnd <= op[1] ? w_abs_b : w_abs_a;
            r_acc  <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            if (op[1] && b == '0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_dbz    <= 1'b1;
              r_result <= {a, {WIDTH{1'b1}}};
            end else begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            r_acc <= r_op[1] ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
